// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, syncs, blank and scan pulses.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [2:0] IDLE = {~HS_POL, ~VS_POL, 1'b0};

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY out of range 0..7");
        end
    endgenerate

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       bl_q, bl_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d  = '0;
                ls_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Flags follow the next counter values so they align with pixel_x/y.
        hs_d = (x_d >= HS_FIRST && x_d <= HS_LAST) ? HS_POL : ~HS_POL;
        vs_d = (y_d >= VS_FIRST && y_d <= VS_LAST) ? VS_POL : ~VS_POL;
        bl_d = (x_d >= H_ACT) || (y_d >= V_ACT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q  <= '0;
            y_q  <= '0;
            hs_q <= IDLE[2];
            vs_q <= IDLE[1];
            bl_q <= IDLE[0];
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            bl_q <= bl_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign {hsync, vsync, blank} = {hs_q, vs_q, bl_q};
        end else begin : g_dly
            logic [2:0] dl_q [SYNC_DELAY];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        dl_q[i] <= IDLE;
                    end
                end else begin
                    dl_q[0] <= {hs_q, vs_q, bl_q};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        dl_q[i] <= dl_q[i-1];
                    end
                end
            end
            assign {hsync, vsync, blank} = dl_q[SYNC_DELAY-1];
        end
    endgenerate

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fc_q <= '0;
        end else if (fs_d) begin
            fc_q <= fc_q + 16'd1;
        end
    end

    assign frame_cnt = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 16x8 raster.
// Two instances compare zero-delay and two-clock sync alignment.
module tb_vga_timing_gen;

    localparam int HT = 16;
    localparam int VT = 8;

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic [9:0] d0_x, d0_y, d2_x, d2_y;
    logic       d0_hs, d0_vs, d0_bl, d0_ls, d0_fs;
    logic       d2_hs, d2_vs, d2_bl, d2_ls, d2_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d0_fc, d2_fc;
    int          fc_e;
`endif

    int         total;
    int         bad;
    int         mx, my;
    logic       ls_e, fs_e;
    logic [2:0] r0, r1, r2;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DELAY(0)
    ) dut0 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .pixel_x(d0_x), .pixel_y(d0_y),
        .hsync(d0_hs), .vsync(d0_vs), .blank(d0_bl),
        .line_start(d0_ls), .frame_start(d0_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d0_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DELAY(2)
    ) dut2 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .pixel_x(d2_x), .pixel_y(d2_y),
        .hsync(d2_hs), .vsync(d2_vs), .blank(d2_bl),
        .line_start(d2_ls), .frame_start(d2_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d2_fc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raster 16x8: active 8x4, hsync x=10..12, vsync y=5..6, low-active.
    function automatic logic [2:0] raw(input int x, input int y);
        logic hs, vs, bl;
        hs = !(x >= 10 && x <= 12);
        vs = !(y >= 5 && y <= 6);
        bl = (x >= 8) || (y >= 4);
        return {hs, vs, bl};
    endfunction

    task automatic do_clk(input logic r, input logic en);
        rst    = r;
        pix_en = en;
        @(posedge clk);
        @(negedge clk);
        r2   = r1;
        r1   = r0;
        ls_e = 1'b0;
        fs_e = 1'b0;
        if (!r) begin
            mx = 0;
            my = 0;
            r1 = 3'b110;
            r2 = 3'b110;
`ifdef VGA_FRAME_CNT_EN
            fc_e = 0;
`endif
        end else if (en) begin
            if (mx == HT - 1) begin
                mx   = 0;
                ls_e = 1'b1;
                if (my == VT - 1) begin
                    my   = 0;
                    fs_e = 1'b1;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
        r0 = raw(mx, my);
        chk("x0", 32'(d0_x), 32'(mx));
        chk("y0", 32'(d0_y), 32'(my));
        chk("ls0", 32'(d0_ls), 32'(ls_e));
        chk("fs0", 32'(d0_fs), 32'(fs_e));
        chk("hs0", 32'(d0_hs), 32'(r0[2]));
        chk("vs0", 32'(d0_vs), 32'(r0[1]));
        chk("bl0", 32'(d0_bl), 32'(r0[0]));
        chk("x2", 32'(d2_x), 32'(mx));
        chk("y2", 32'(d2_y), 32'(my));
        chk("ls2", 32'(d2_ls), 32'(ls_e));
        chk("fs2", 32'(d2_fs), 32'(fs_e));
        chk("hs2", 32'(d2_hs), 32'(r2[2]));
        chk("vs2", 32'(d2_vs), 32'(r2[1]));
        chk("bl2", 32'(d2_bl), 32'(r2[0]));
`ifdef VGA_FRAME_CNT_EN
        if (r && fs_e) fc_e = (fc_e + 1) % 65536;
        chk("fc0", 32'(d0_fc), 32'(fc_e));
        chk("fc2", 32'(d2_fc), 32'(fc_e));
`endif
    endtask

    int   hs_lo, vs_lo, bl_hi, ls_n, fs_n, ls_dbl;
    int   hfall0, hfall2, hfallx, brise0, brise2, fs_c0, fs_c1;
    logic p_hs0, p_hs2, p_bl0, p_bl2, p_ls;

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        pix_en = 1'b0;
        mx = 0; my = 0;
        r0 = 3'b110; r1 = 3'b110; r2 = 3'b110;
`ifdef VGA_FRAME_CNT_EN
        fc_e = 0;
`endif

        do_clk(1'b0, 1'b0);
        do_clk(1'b0, 1'b1);

        // Full-rate scan, two frames.
        hs_lo = 0; vs_lo = 0; bl_hi = 0; ls_n = 0; fs_n = 0;
        hfall0 = -1; hfall2 = -1; hfallx = -1; brise0 = -1; brise2 = -1;
        p_hs0 = 1'b1; p_hs2 = 1'b1; p_bl0 = 1'b0; p_bl2 = 1'b0;
        for (int i = 1; i <= 2 * HT * VT; i++) begin
            do_clk(1'b1, 1'b1);
            if (i <= HT * VT) begin
                hs_lo += int'(!d0_hs);
                vs_lo += int'(!d0_vs);
                bl_hi += int'(d0_bl);
                ls_n  += int'(d0_ls);
                fs_n  += int'(d0_fs);
                if (p_hs0 && !d0_hs && hfall0 < 0) begin
                    hfall0 = i;
                    hfallx = int'(d0_x);
                end
                if (p_hs2 && !d2_hs && hfall2 < 0) hfall2 = i;
                if (!p_bl0 && d0_bl && brise0 < 0) brise0 = i;
                if (!p_bl2 && d2_bl && brise2 < 0) brise2 = i;
            end
            p_hs0 = d0_hs; p_hs2 = d2_hs; p_bl0 = d0_bl; p_bl2 = d2_bl;
        end
        chk("hs_low_cnt", 32'(hs_lo), 32'd24);
        chk("vs_low_cnt", 32'(vs_lo), 32'd32);
        chk("bl_high_cnt", 32'(bl_hi), 32'd96);
        chk("ls_per_frame", 32'(ls_n), 32'd8);
        chk("fs_per_frame", 32'(fs_n), 32'd1);
        chk("hs_fall_x", 32'(hfallx), 32'd10);
        chk("hs_fall_delay", 32'(hfall2 - hfall0), 32'd2);
        chk("bl_rise_at", 32'(brise0), 32'd8);
        chk("bl_rise_delay", 32'(brise2 - brise0), 32'd2);

        // Half-rate enable, two frames.
        do_clk(1'b0, 1'b0);
        ls_n = 0; fs_n = 0; ls_dbl = 0; fs_c0 = -1; fs_c1 = -1; p_ls = 1'b0;
        for (int i = 0; i < 4 * HT * VT; i++) begin
            do_clk(1'b1, (i % 2) == 0);
            ls_n += int'(d0_ls);
            if (p_ls && d0_ls) ls_dbl++;
            p_ls = d0_ls;
            if (d0_fs) begin
                fs_n++;
                if (fs_c0 < 0) fs_c0 = i;
                else fs_c1 = i;
            end
        end
        chk("half_fs_cnt", 32'(fs_n), 32'd2);
        chk("half_fs_gap", 32'(fs_c1 - fs_c0), 32'd256);
        chk("half_fs_first", 32'(fs_c0), 32'd254);
        chk("half_ls_cnt", 32'(ls_n), 32'd16);
        chk("half_ls_width", 32'(ls_dbl), 32'd0);

        // Mid-frame reset with enable high, inside the hsync pulse.
        for (int i = 0; i < 59; i++) do_clk(1'b1, 1'b1);
        chk("pre_rst_x", 32'(d0_x), 32'd11);
        chk("pre_rst_y", 32'(d0_y), 32'd3);
        chk("pre_rst_hs", 32'(d0_hs), 32'd0);
        do_clk(1'b0, 1'b1);
        chk("rst_mid_x", 32'(d0_x), 32'd0);
        chk("rst_mid_hs2", 32'(d2_hs), 32'd1);
        chk("rst_mid_fs", 32'(d0_fs), 32'd0);
        do_clk(1'b1, 1'b1);
        chk("post_rst_x", 32'(d0_x), 32'd1);

        // Reset with enable low, then hold and resume.
        for (int i = 0; i < 20; i++) do_clk(1'b1, 1'b1);
        do_clk(1'b0, 1'b0);
        chk("rst_noen_x", 32'(d0_x), 32'd0);
        chk("rst_noen_y", 32'(d0_y), 32'd0);
        do_clk(1'b1, 1'b0);
        do_clk(1'b1, 1'b0);
        chk("hold_x", 32'(d0_x), 32'd0);
        do_clk(1'b1, 1'b1);
        chk("resume_x", 32'(d0_x), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator that sits directly upstream of the pixel logic stage. Produces the pixel_x/pixel_y scan coordinates it consumes, plus hsync, vsync and blank for the DAC/connector. Counters advance on a pixel-clock enable derived from the system clock. An optional sync delay line re-aligns the syncs with the colour outputs of the downstream drawing stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
SYNC_DELAY, 2, clk cycles of delay applied to hsync/vsync/blank (0..7)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
pix_en  input  1  pixel-clock enable; counters advance only when 1
pixel_x  output  10  horizontal counter, 0..H_TOTAL-1
pixel_y  output  10  vertical counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per HS_POL, delayed SYNC_DELAY
vsync  output  1  vertical sync, polarity per VS_POL, delayed SYNC_DELAY
blank  output  1  1 outside the active area, delayed SYNC_DELAY
line_start  output  1  one-clk pulse when pixel_x wraps to 0
frame_start  output  1  one-clk pulse when (pixel_x,pixel_y) wraps to (0,0)

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk and rst. rst is sampled only on the rising edge of clk.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024. Elaboration error otherwise, or if SYNC_DELAY > 7.
- Reset (rst=0 at edge): pixel_x=0, pixel_y=0, line_start=0, frame_start=0, blank=0. hsync = ~HS_POL and vsync = ~VS_POL (inactive). All delay-line stages are loaded with these same inactive values. Reset overrides pix_en.
- Counting happens on an edge with rst=1 and pix_en=1:
  - If pixel_x == H_TOTAL-1, pixel_x goes to 0. Otherwise pixel_x increments.
  - On the pixel_x wrap, pixel_y increments, or goes to 0 if pixel_y == V_TOTAL-1.
  - pix_en=0: all counters and undelayed flags hold.
- Undelayed flags are registered and computed from the next counter values, so they have zero skew with pixel_x/pixel_y:
  - hs_raw active iff pixel_x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
  - vs_raw active iff pixel_y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491). vs_raw is a whole-line decision.
  - bl_raw = (pixel_x ≥ H_ACTIVE) | (pixel_y ≥ V_ACTIVE).
- line_start is 1 for exactly the one clk in which pixel_x has just become 0 via a wrap. frame_start likewise, when both counters have just become 0 via a wrap. Neither pulses on exit from reset. Both are 0 in all other cycles, including pix_en=0 cycles.
- Delay line:
  - hsync/vsync/blank = hs_raw/vs_raw/bl_raw delayed by SYNC_DELAY clk cycles (shift register clocked every clk, not gated by pix_en).
  - SYNC_DELAY=0 connects the outputs directly to the raw registers.
  - pixel_x, pixel_y, line_start and frame_start are not delayed.
- Reset asserted mid-frame takes effect on the next edge. Scanning restarts at (0,0) on the first enabled edge after release.

Optional Feature:
VGA_FRAME_CNT_EN:
- Defined: adds output port frame_cnt [15:0]. It resets to 0, increments in the same cycle frame_start asserts, and wraps 0xFFFF->0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then pix_en=1 every clk: pixel_x counts 0..799 then 0, pixel_y increments at each wrap. line_start pulses every 800 clk. frame_start pulses every 420000 clk.
- SYNC_DELAY=0, pix_en constant 1: hsync=0 exactly for pixel_x 656..751 (96 clk per line). vsync=0 for pixel_y 490..491 (1600 clk). blank=1 for pixel_x≥640 or pixel_y≥480.
- SYNC_DELAY=2: hsync falling edge occurs 2 clk after pixel_x reaches 656. blank rises 2 clk after pixel_x=640.
- pix_en toggling 1,0,1,0 (50 MHz clk, 25 MHz pixel): counters advance every other clk. Full frame = 840000 clk. line_start/frame_start are each high for one clk only.
- Assert rst=0 for 1 clk with pixel_x=700, pixel_y=300 and pix_en=1: the next cycle shows (0,0), hsync=1, vsync=1, blank=0, no frame_start pulse. A rst asserted with pix_en=0 also resets.
- With VGA_FRAME_CNT_EN: after 3 complete frames from reset, frame_cnt=3. Force frame_cnt to 0xFFFF and complete one frame: frame_cnt=0.
